// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state encoding and default sizing for the mux pipeline
package mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/muxn.sv
// rtl/muxn.sv - combinational NCH-to-1 word selector, zero for an out-of-range select
module muxn #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data
);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - NCH-way word selector feeding a 2-entry skid buffer with valid/ready on both sides
// Optional MUX_PIPE_SELCHK_EN: drop out-of-range selects and pulse sel_err instead of forwarding a zero word.
module mux_pipe_n
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_PIPE_SELCHK_EN
  ,
  output logic                 sel_err
`endif
);

  logic [WIDTH-1:0] mux_word;

  muxn #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) u_muxn (
    .in_data (in_data),
    .sel     (in_sel),
    .out_data(mux_word)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, drain, push;

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != ST_EMPTY) && out_ready;

`ifdef MUX_PIPE_SELCHK_EN
  logic sel_bad;
  logic sel_err_q, sel_err_d;

  // Widened by one bit so the compare against NCH never truncates.
  assign sel_bad   = {1'b0, in_sel} >= (SEL_W + 1)'(NCH);
  assign push      = accept && !sel_bad;
  assign sel_err_d = accept && sel_bad;
  assign sel_err   = sel_err_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end
`else
  assign push = accept;
`endif

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_data_d = mux_word;
          main_sel_d  = in_sel;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({push, drain})
          2'b10: begin
            skid_data_d = mux_word;
            skid_sel_d  = in_sel;
            state_d     = ST_TWO;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: begin
            main_data_d = mux_word;
            main_sel_d  = in_sel;
          end
          default: ;
        endcase
      end
      ST_TWO: begin
        if (drain) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready looks at the next state, keeping out_ready off the in_ready path.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - scoreboard bench for mux_pipe_n (4-channel stream plus 3-channel select check)
module tb_mux_pipe_n;

  logic         clk = 1'b0;
  logic         clrn;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid, out_ready;

  logic [23:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3, in_ready3;
  logic [7:0]   out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3, out_ready3;
`ifdef MUX_PIPE_SELCHK_EN
  logic         sel_err, sel_err3;
`endif

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(32), .NCH(4)) dut (
    .clk(clk), .clrn(clrn), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_PIPE_SELCHK_EN
    , .sel_err(sel_err)
`endif
  );

  mux_pipe_n #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .clrn(clrn), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_PIPE_SELCHK_EN
    , .sel_err(sel_err3)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } beat_t;

  beat_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          hold_chk = 0;
  logic [33:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] s);
    return in_data[s*32 +: 32];
  endfunction

  always @(negedge clk) begin
    if (clrn) begin
      int    occ;
      beat_t h;
      occ = sb.size();
      check("out_valid", out_valid, occ != 0);
      check("in_ready", in_ready, occ != 2);
      if (hold_chk) check("hold", {out_data, out_sel}, held);
      if (out_valid && out_ready && occ != 0) begin
        h = sb.pop_front();
        check("out_data", out_data, h.d);
        check("out_sel", out_sel, h.s);
      end
      if (in_valid && occ != 2) sb.push_back('{d: exp_word(in_sel), s: in_sel});
      hold_chk = out_valid && !out_ready;
      held     = {out_data, out_sel};
    end
  end

  task automatic send(input logic [1:0] s);
    logic acc;
    bit   done;
    done     = 0;
    in_valid = 1'b1;
    in_sel   = s;
    for (int t = 0; t < 100 && !done; t++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      done = acc;
    end
    check("send_accept", done, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0;
    in_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    in_data3 = {8'h33, 8'h22, 8'h11}; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_in_ready", in_ready, 1);
    clrn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Streaming, no bubbles with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(2'(i));
    wait_empty();

    // Backpressure: three beats queued against a stalled sink.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          in_data = {$urandom, $urandom, $urandom, $urandom};
          send(2'($urandom_range(0, 3)));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_back", in_ready, 1);
      end
    join
    wait_empty();

    // Accept and drain together while holding one beat.
    out_ready = 1'b0;
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    send(2'd1);
    out_ready = 1'b1;
    send(2'd2);
    check("one_swap_valid", out_valid, 1);
    check("one_swap_data", out_data, 32'h33333333);
    check("one_swap_sel", out_sel, 2);
    wait_empty();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    send(2'd0);
    send(2'd3);
    check("full_in_ready", in_ready, 0);
    #3;
    clrn = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    sb.delete();
    hold_chk = 0;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    check("arst_gone", out_valid, 0);

    // Out-of-range select on the 3-channel instance.
    in_sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b0;
    @(posedge clk); #1;
    in_sel3 = 2'd1; out_ready3 = 1'b1;
`ifdef MUX_PIPE_SELCHK_EN
    check("selerr_pulse", sel_err3, 1);
    check("selerr_no_store", out_valid3, 0);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    check("selerr_clear", sel_err3, 0);
`else
    check("badsel_valid", out_valid3, 1);
    check("badsel_data", out_data3, 0);
    check("badsel_sel", out_sel3, 3);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
`endif
    check("ch3_valid", out_valid3, 1);
    check("ch3_data", out_data3, 8'h22);
    check("ch3_sel", out_sel3, 1);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
